spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 44 ++++
 rtl/spi_slave.sv | 213 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg
//   Shared types and constants for the SPI mode-3 slave.
//   state_e     : link state (IDLE = chip select released, ACTIVE = selected)
//   SYNC_STAGES : depth of the input synchronizers
//   FILL_BYTE   : byte shifted out when the transmit buffer is empty
//   MISO_IDLE   : level driven on SPI_MISO outside a byte transfer
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;
  localparam logic       MISO_IDLE   = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Brings one asynchronous input into the clk domain through a
//   SYNC_STAGES-deep flop chain and flags its rising and falling edges.
//   Ports:
//     clk   : system clock
//     srst  : synchronous active-high reset (chain and history load RESET_VAL)
//     din   : asynchronous input
//     rise  : one-cycle pulse, synchronized input went 0 -> 1
//     fall  : one-cycle pulse, synchronized input went 1 -> 0
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      // History matches the chain so no spurious edge follows reset.
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave
//   SPI mode-3 (CPOL=1, CPHA=1) byte slave, MSB first, fully synchronous to CLK.
//   Master pins are oversampled, so SCK phases must last at least 4 CLK.
//   Ports:
//     CLK, RST          : system clock, synchronous active-high reset
//     SPI_CS            : chip select from master, active-low, asynchronous
//     SPI_SCK, SPI_MOSI : serial clock (idle high) and data from master
//     SPI_MISO          : registered serial data to master
//     rx_data/rx_valid  : last received byte and its unread flag
//     rx_ack            : consumer read strobe
//     tx_data/tx_load   : next byte to send and its write strobe
//     tx_ready          : transmit buffer empty
//     rx_overrun        : sticky, an unread byte was overwritten
//     tx_underrun       : sticky, a byte started with an empty tx buffer
//     clr_flags         : clears both sticky flags
//     busy              : chip select is active
module spi_slave
  import spi_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       SPI_CS,
  input  logic       SPI_SCK,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       rx_overrun,
  output logic       tx_underrun,
  input  logic       clr_flags,
  output logic       busy
);

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sck_sync (
    .clk  (CLK),
    .srst (RST),
    .din  (SPI_SCK),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk  (CLK),
    .srst (RST),
    .din  (SPI_CS),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // MOSI needs no edge detection, only a chain of the same depth so it
  // stays aligned with the synchronized SCK.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;   // first seven bits of the byte in flight
  logic [6:0] tx_shift_q, tx_shift_d;   // bits still to send after the one on MISO
  logic       miso_q, miso_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_ready_q, tx_ready_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic       tx_underrun_q, tx_underrun_d;

  logic [7:0] load_val;
  logic       byte_done;
  logic       overrun_set;
  logic       underrun_set;

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};

    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    miso_d        = miso_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    tx_buf_d      = tx_buf_q;
    tx_ready_d    = tx_ready_q;
    rx_overrun_d  = rx_overrun_q;
    tx_underrun_d = tx_underrun_q;
    byte_done     = 1'b0;
    overrun_set   = 1'b0;
    underrun_set  = 1'b0;

    load_val = tx_ready_q ? FILL_BYTE : tx_buf_q;

    // A write is only accepted into an empty buffer. Acceptance uses the
    // registered tx_ready, so a write coinciding with an empty-buffer load
    // still lands in the buffer while the shifter gets the fill byte.
    if (tx_load && tx_ready_q) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = 3'd0;
          miso_d    = MISO_IDLE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // Deselect abandons any partial byte in either direction.
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          miso_d    = MISO_IDLE;
        end else begin
          if (sck_fall) begin
            if (bit_cnt_q == 3'd0) begin
              tx_shift_d = load_val[6:0];
              miso_d     = load_val[7];
              if (tx_ready_q) begin
                underrun_set = 1'b1;
              end else begin
                tx_ready_d = 1'b1;
              end
            end else begin
              miso_d     = tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
            end
          end
          if (sck_rise) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end
    if (byte_done) begin
      rx_data_d  = {rx_shift_q, mosi_s};
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) begin
        overrun_set = 1'b1;
      end
    end

    // Clear first so a simultaneous set event wins.
    if (clr_flags) begin
      rx_overrun_d  = 1'b0;
      tx_underrun_d = 1'b0;
    end
    if (overrun_set) begin
      rx_overrun_d = 1'b1;
    end
    if (underrun_set) begin
      tx_underrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mosi_sync_q   <= {SYNC_STAGES{1'b1}};
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 7'd0;
      tx_shift_q    <= 7'd0;
      miso_q        <= MISO_IDLE;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      tx_buf_q      <= 8'h00;
      tx_ready_q    <= 1'b1;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      mosi_sync_q   <= mosi_sync_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      miso_q        <= miso_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_buf_q      <= tx_buf_d;
      tx_ready_q    <= tx_ready_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign SPI_MISO    = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SPI_CS = 1'b1;
  logic       SPI_SCK = 1'b1;
  logic       SPI_MOSI = 1'b1;
  logic       SPI_MISO;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       clr_flags = 1'b0;
  logic       busy;

  always #5 CLK = ~CLK;

  spi_slave dut (
    .CLK        (CLK),
    .RST        (RST),
    .SPI_CS     (SPI_CS),
    .SPI_SCK    (SPI_SCK),
    .SPI_MOSI   (SPI_MOSI),
    .SPI_MISO   (SPI_MISO),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .rx_overrun (rx_overrun),
    .tx_underrun(tx_underrun),
    .clr_flags  (clr_flags),
    .busy       (busy)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard of bytes the consumer should see presented on rx_valid.
  logic [7:0] rx_q[$];

  // Reference model of the transmit side: a one-entry buffer.
  bit         model_full = 1'b0;
  logic [7:0] model_buf = 8'h00;
  bit         model_underrun = 1'b0;
  bit         rand_phase = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic int half_period();
    if (rand_phase) return int'($urandom_range(4, 7));
    return 5;
  endfunction

  // Monitor: every new presentation of a byte pops one expectation.
  logic prev_valid = 1'b0;
  always @(posedge CLK) begin
    #1;
    if (rx_valid && !prev_valid) begin
      checks++;
      if (rx_q.size() == 0) begin
        failures++;
        $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
      end else begin
        logic [7:0] exp_b;
        exp_b = rx_q.pop_front();
        if (rx_data !== exp_b) begin
          failures++;
          $display("FAIL rx_byte actual=%0h required=%0h", rx_data, exp_b);
        end else begin
          $display("rx byte %02h", rx_data);
        end
      end
    end
    prev_valid = rx_valid;
  end

  task automatic do_load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    wait_clks(1);
    tx_load = 1'b0;
    if (!model_full) begin
      model_buf  = d;
      model_full = 1'b1;
    end
    chk("tx_ready_after_load", 32'(tx_ready), 32'(!model_full));
  endtask

  task automatic cs_low();
    SPI_CS = 1'b0;
    wait_clks(4);
  endtask

  task automatic cs_high();
    SPI_CS = 1'b1;
    wait_clks(4);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    wait_clks(1);
    rx_ack = 1'b0;
    wait_clks(1);
    chk("rx_valid_after_ack", 32'(rx_valid), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    wait_clks(1);
    clr_flags = 1'b0;
    model_underrun = 1'b0;
    chk("overrun_cleared", 32'(rx_overrun), 32'd0);
    chk("underrun_cleared", 32'(tx_underrun), 32'd0);
  endtask

  // Master side of one mode-3 byte (or nbits of it). MOSI changes on the
  // falling SCK edge; MISO is sampled just before the rising edge.
  task automatic spi_xfer(input logic [7:0] mosi, input int nbits, input bit lat_chk,
                          input bit ack_on_done, input bit push, output logic [7:0] miso);
    logic [7:0] exp_tx;
    int hp;
    miso = 8'h00;
    exp_tx = model_full ? model_buf : 8'hFF;
    if (!model_full) model_underrun = 1'b1;
    model_full = 1'b0;
    if (push && nbits == 8) rx_q.push_back(mosi);
    for (int i = 0; i < nbits; i++) begin
      hp = half_period();
      SPI_SCK = 1'b0;
      SPI_MOSI = mosi[7-i];
      wait_clks(hp);
      miso[7-i] = SPI_MISO;
      SPI_SCK = 1'b1;
      hp = half_period();
      if (i == 7 && (lat_chk || ack_on_done)) begin
        wait_clks(2);
        if (lat_chk) chk("rx_latency_2clk", 32'(rx_valid), 32'd0);
        if (ack_on_done) rx_ack = 1'b1;
        wait_clks(1);
        rx_ack = 1'b0;
        if (lat_chk) chk("rx_latency_3clk", 32'(rx_valid), 32'd1);
        wait_clks(hp - 3);
      end else begin
        wait_clks(hp);
      end
    end
    if (nbits == 8) begin
      $display("xfer mosi=%02h miso=%02h expected_miso=%02h", mosi, miso, exp_tx);
      chk("miso_byte", 32'(miso), 32'(exp_tx));
      chk("tx_underrun_model", 32'(tx_underrun), 32'(model_underrun));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] m;
    logic [7:0] d;
    int nb;

    wait_clks(3);
    RST = 1'b0;
    wait_clks(1);
    chk("reset_miso", 32'(SPI_MISO), 32'd1);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_tx_ready", 32'(tx_ready), 32'd1);
    chk("reset_overrun", 32'(rx_overrun), 32'd0);
    chk("reset_underrun", 32'(tx_underrun), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Basic byte with exact receive latency.
    do_load(8'hA5);
    cs_low();
    chk("busy_active", 32'(busy), 32'd1);
    spi_xfer(8'h3C, 8, 1'b1, 1'b0, 1'b1, m);
    chk("miso_a5", 32'(m), 32'hA5);
    pulse_ack();
    cs_high();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("miso_idle", 32'(SPI_MISO), 32'd1);

    // Overrun, underrun, clear, and ack on the completion cycle.
    cs_low();
    spi_xfer(8'h11, 8, 1'b0, 1'b0, 1'b1, m);
    spi_xfer(8'h22, 8, 1'b0, 1'b0, 1'b0, m);
    chk("overrun_data", 32'(rx_data), 32'h22);
    chk("overrun_flag", 32'(rx_overrun), 32'd1);
    chk("underrun_flag", 32'(tx_underrun), 32'd1);
    chk("underrun_miso", 32'(m), 32'hFF);
    pulse_clr();
    spi_xfer(8'h33, 8, 1'b0, 1'b1, 1'b0, m);
    chk("ack_same_valid", 32'(rx_valid), 32'd1);
    chk("ack_same_data", 32'(rx_data), 32'h33);
    chk("ack_same_no_overrun", 32'(rx_overrun), 32'd0);
    pulse_ack();
    cs_high();

    // Deselect mid-byte discards it.
    cs_low();
    spi_xfer(8'hF0, 4, 1'b0, 1'b0, 1'b0, m);
    cs_high();
    chk("abort_no_valid", 32'(rx_valid), 32'd0);
    chk("abort_miso", 32'(SPI_MISO), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    cs_low();
    spi_xfer(8'h81, 8, 1'b0, 1'b0, 1'b1, m);
    pulse_ack();
    cs_high();

    // Reset in the middle of a byte.
    do_load(8'h77);
    cs_low();
    spi_xfer(8'hC3, 3, 1'b0, 1'b0, 1'b0, m);
    RST = 1'b1;
    SPI_CS = 1'b1;
    wait_clks(1);
    chk("midrst_miso", 32'(SPI_MISO), 32'd1);
    chk("midrst_rx_data", 32'(rx_data), 32'h00);
    chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
    chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
    chk("midrst_overrun", 32'(rx_overrun), 32'd0);
    chk("midrst_underrun", 32'(tx_underrun), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    RST = 1'b0;
    model_full = 1'b0;
    model_underrun = 1'b0;
    wait_clks(4);
    cs_low();
    spi_xfer(8'h5A, 8, 1'b0, 1'b0, 1'b1, m);
    pulse_ack();
    cs_high();

    // Second write into a full buffer is ignored.
    pulse_clr();
    do_load(8'h01);
    do_load(8'h02);
    cs_low();
    spi_xfer(8'hE7, 8, 1'b0, 1'b0, 1'b1, m);
    chk("double_load_miso", 32'(m), 32'h01);
    pulse_ack();
    cs_high();

    // Randomized sessions against the model.
    rand_phase = 1'b1;
    for (int s = 0; s < 4; s++) begin
      cs_low();
      nb = int'($urandom_range(3, 6));
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
        d = 8'($urandom);
        spi_xfer(d, 8, 1'b0, 1'b0, 1'b1, m);
        chk("rand_no_overrun", 32'(rx_overrun), 32'd0);
        pulse_ack();
        if ($urandom_range(0, 3) == 0) pulse_clr();
      end
      cs_high();
      chk("rand_busy_idle", 32'(busy), 32'd0);
    end

    wait_clks(10);
    chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
